// File: rtl/led_seq_pkg.sv
// led_seq_pkg: shared types and helpers for the LED sequencer.
// Holds the display mode encoding, the controller state encoding and
// the per-mode initial pattern used whenever a mode (re)starts.
package led_seq_pkg;

    typedef enum logic [1:0] {
        MODE_COUNT = 2'd0,
        MODE_CHASE = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_FILL  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        RUN       = 2'd1,
        HOLD      = 2'd2
    } state_e;

    // Widest LED vector the helper below can describe; callers truncate.
    localparam int MAX_WIDTH = 64;

    // Initial pattern of a mode, returned at MAX_WIDTH and sized down by the caller.
    function automatic logic [MAX_WIDTH-1:0] init_pattern(input mode_e m);
        logic [MAX_WIDTH-1:0] pat;
        case (m)
            MODE_CHASE: pat = MAX_WIDTH'(1);
            MODE_BLINK: pat = '1;
            default:    pat = '0;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/led_sequencer_if.sv
// led_sequencer_if: mode-change request channel (valid/ready) of the LED sequencer.
// The requester uses the master modport, the sequencer the slave modport.
interface led_sequencer_if;
    import led_seq_pkg::*;

    logic  mode_valid;
    mode_e mode;
    logic  mode_ready;

    modport master (output mode_valid, output mode, input mode_ready);
    modport slave  (input mode_valid, input mode, output mode_ready);

endinterface

// File: rtl/led_sequencer_tick_prescaler.sv
// tick_prescaler: divides impulse ticks into display steps.
// Counts impulses unless held, returns to zero on clear, and flags the
// impulse that completes a group of PRESCALE ticks.
module tick_prescaler #(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic hold,
    input  logic impulse,
    output logic step_en
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          counting;

    assign counting = impulse & ~hold & ~clear;
    assign step_en  = counting & (count_q == LAST);

    // Next count: clear wins, otherwise advance on a counted impulse and wrap after LAST.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (counting) begin
            count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/led_sequencer.sv
// led_sequencer: LED display controller on the PLL clock.
// Waits for PLL lock, divides impulse ticks into steps and sequences one of
// four patterns; mode changes are buffered one deep and applied at a step.
// Optional feature macro LED_SEQ_GRAY_EN: COUNT mode shows the Gray code of
// the internal counter instead of the plain binary value.
module led_sequencer
    import led_seq_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int PRESCALE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             locked,
    input  logic             impulse,
    input  logic             pause,
    led_sequencer_if.slave   mode_if,
    output logic [WIDTH-1:0] led,
    output logic             step
);

    localparam logic [1:0] ST_WAIT_LOCK = WAIT_LOCK;
    localparam logic [1:0] ST_RUN       = RUN;
    localparam logic [1:0] ST_HOLD      = HOLD;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] pat_q, pat_d;
    mode_e            mode_q, mode_d;
    logic             pend_valid_q, pend_valid_d;
    mode_e            pend_mode_q, pend_mode_d;
    logic             step_q;
    logic             step_en;
    logic             accept;

    // Next pattern of a running mode; pat is the raw counter in COUNT mode.
    function automatic logic [WIDTH-1:0] advance(input mode_e m, input logic [WIDTH-1:0] pat);
        logic [WIDTH-1:0] nxt;
        case (m)
            MODE_CHASE: nxt = {pat[WIDTH-2:0], pat[WIDTH-1]};
            MODE_BLINK: nxt = ~pat;
            MODE_FILL:  nxt = (&pat) ? '0 : {pat[WIDTH-2:0], 1'b1};
            default:    nxt = pat + 1'b1;
        endcase
        return nxt;
    endfunction

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk     (clk),
        .rst     (rst),
        .clear   (~locked),
        .hold    (state_q != ST_RUN),
        .impulse (impulse),
        .step_en (step_en)
    );

    assign accept             = mode_if.mode_valid & ~pend_valid_q;
    assign mode_if.mode_ready = ~pend_valid_q;
    assign step               = step_q;

`ifdef LED_SEQ_GRAY_EN
    assign led = (mode_q == MODE_COUNT) ? (pat_q ^ (pat_q >> 1)) : pat_q;
`else
    assign led = pat_q;
`endif

    // Controller: lock gating, pause handling, step updates and the request buffer.
    always_comb begin
        state_d      = state_q;
        pat_d        = pat_q;
        mode_d       = mode_q;
        pend_valid_d = pend_valid_q;
        pend_mode_d  = pend_mode_q;

        if (accept) begin
            pend_valid_d = 1'b1;
            pend_mode_d  = mode_if.mode;
        end

        if (!locked) begin
            state_d = ST_WAIT_LOCK;
            pat_d   = '0;
        end else begin
            case (state_q)
                ST_WAIT_LOCK: begin
                    state_d = ST_RUN;
                    pat_d   = WIDTH'(init_pattern(mode_q));
                end
                ST_RUN: begin
                    if (pause) begin
                        state_d = ST_HOLD;
                    end
                    if (step_en) begin
                        if (pend_valid_q) begin
                            mode_d       = pend_mode_q;
                            pat_d        = WIDTH'(init_pattern(pend_mode_q));
                            pend_valid_d = 1'b0;
                        end else begin
                            pat_d = advance(mode_q, pat_q);
                        end
                    end
                end
                ST_HOLD: begin
                    if (!pause) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_WAIT_LOCK;
                    pat_d   = '0;
                end
            endcase
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_WAIT_LOCK;
            pat_q        <= '0;
            mode_q       <= MODE_COUNT;
            pend_valid_q <= 1'b0;
            pend_mode_q  <= MODE_COUNT;
            step_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pat_q        <= pat_d;
            mode_q       <= mode_d;
            pend_valid_q <= pend_valid_d;
            pend_mode_q  <= pend_mode_d;
            step_q       <= step_en;
        end
    end

endmodule

// File: tb/tb_led_sequencer.sv
// tb_led_sequencer: self-checking bench for led_sequencer (WIDTH=16, PRESCALE=4).
// A reference model tracks the display as "mode plus number of steps since the
// mode started" and derives the expected LED value arithmetically.
// Honours LED_SEQ_GRAY_EN in the same way as the design.
module tb_led_sequencer;
    import led_seq_pkg::*;

    localparam int W  = 16;
    localparam int PS = 4;

    localparam int MP_WAIT = 0;
    localparam int MP_RUN  = 1;
    localparam int MP_HOLD = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         locked;
    logic         impulse;
    logic         pause;
    logic [W-1:0] led;
    logic         step;

    led_sequencer_if mIf ();

    led_sequencer #(
        .WIDTH    (W),
        .PRESCALE (PS)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .locked  (locked),
        .impulse (impulse),
        .pause   (pause),
        .mode_if (mIf),
        .led     (led),
        .step    (step)
    );

    always #5 clk = ~clk;

    int     total = 0;
    int     bad   = 0;

    int     mPhase;
    int     mTicks;
    int     mMode;
    longint mK;
    bit     mPend;
    int     mPendMode;
    bit     mStep;
    bit     lastAccept;

    // Compare one observed value with its expected value and count the result.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Expected display value derived from the mode and step count.
    function automatic logic [W-1:0] expLed();
        longint v;
        int     n;
        v = 0;
        if (mPhase == MP_WAIT) return '0;
        case (mMode)
            0: begin
                v = mK % (longint'(1) << W);
`ifdef LED_SEQ_GRAY_EN
                v = v ^ (v >> 1);
`endif
            end
            1: v = longint'(1) << (mK % W);
            2: v = (mK % 2 == 0) ? (longint'(1) << W) - 1 : 0;
            default: begin
                n = int'(mK % (W + 1));
                v = (longint'(1) << n) - 1;
            end
        endcase
        return v[W-1:0];
    endfunction

    // Advance the reference model by one clock edge with the given inputs.
    task automatic modelEdge(input bit r, input bit l, input bit imp, input bit p, input bit v, input int m);
        bit accept;
        accept     = v && !mPend;
        lastAccept = 1'b0;
        mStep      = 1'b0;
        if (!r) begin
            mPhase = MP_WAIT; mTicks = 0; mMode = 0; mK = 0;
            mPend  = 1'b0;    mPendMode = 0;
            return;
        end
        if (!l) begin
            mPhase = MP_WAIT;
            mTicks = 0;
        end else begin
            case (mPhase)
                MP_WAIT: begin
                    mPhase = MP_RUN;
                    mK     = 0;
                end
                MP_RUN: begin
                    if (imp) begin
                        if (mTicks == PS - 1) begin
                            mTicks = 0;
                            mStep  = 1'b1;
                        end else begin
                            mTicks++;
                        end
                    end
                    if (mStep) begin
                        if (mPend) begin
                            mMode = mPendMode;
                            mK    = 0;
                            mPend = 1'b0;
                        end else begin
                            mK++;
                        end
                    end
                    if (p) mPhase = MP_HOLD;
                end
                default: begin
                    if (!p) mPhase = MP_RUN;
                end
            endcase
        end
        if (accept) begin
            mPend      = 1'b1;
            mPendMode  = m;
            lastAccept = 1'b1;
        end
    endtask

    // Drive one cycle of inputs, step the model at the edge and check all outputs.
    task automatic applyStimulus(input bit r, input bit l, input bit imp, input bit p, input bit v, input int m);
        rst            = r;
        locked         = l;
        impulse        = imp;
        pause          = p;
        mIf.mode_valid = v;
        mIf.mode       = mode_e'(m[1:0]);
        @(posedge clk);
        modelEdge(r, l, imp, p, v, m);
        #1;
        checkOutput("led", 32'(led), 32'(expLed()));
        checkOutput("step", 32'(step), 32'(mStep));
        checkOutput("mode_ready", 32'(mIf.mode_ready), 32'(!mPend));
    endtask

    initial begin
        bit filled;
        bit pauseLvl;
        int lockLow;

        // Reset for three cycles with the PLL already locked.
        for (int c = 0; c < 3; c++) applyStimulus(0, 1, 0, 0, 0, 0);
        checkOutput("reset_led", 32'(led), 32'd0);
        checkOutput("reset_ready", 32'(mIf.mode_ready), 32'd1);

        // COUNT with an impulse every 10 cycles.
        for (int c = 0; c < 90; c++) applyStimulus(1, 1, (c % 10 == 9), 0, 0, 0);

        // Switch to CHASE and run through a full rotation and wrap.
        applyStimulus(1, 1, 0, 0, 1, 1);
        for (int c = 0; c < 150; c++) applyStimulus(1, 1, (c % 2 == 0), 0, 0, 0);

        // Pause across several impulses, then resume.
        for (int c = 0; c < 30; c++) applyStimulus(1, 1, (c % 5 == 2), (c >= 3 && c < 25), 0, 0);

        // Back-to-back requests: BLINK is taken, FILL stalls until BLINK is applied.
        applyStimulus(1, 1, 0, 0, 1, 2);
        filled = 1'b0;
        for (int c = 0; c < 200 && !filled; c++) begin
            applyStimulus(1, 1, (c % 2 == 0), 0, 1, 3);
            filled = lastAccept;
        end
        if (!filled) checkOutput("fill_accept_timeout", 32'd0, 32'd1);

        // Let FILL run, drop lock for a few cycles, then relock.
        for (int c = 0; c < 45; c++) applyStimulus(1, 1, 1, 0, 0, 0);
        for (int c = 0; c < 3; c++) applyStimulus(1, 0, 1, 0, 0, 0);
        for (int c = 0; c < 30; c++) applyStimulus(1, 1, 1, 0, 0, 0);

        // Randomised traffic on every input.
        pauseLvl = 1'b0;
        lockLow  = 0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 39) == 0) pauseLvl = !pauseLvl;
            if (lockLow > 0) lockLow--;
            else if ($urandom_range(0, 199) == 0) lockLow = int'($urandom_range(1, 5));
            applyStimulus(1, (lockLow == 0), ($urandom_range(0, 2) == 0), pauseLvl,
                          ($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
